// File: rtl/fp_alu_seq_if.sv
// ---------------------------------------------------------------------------
// fp_alu_seq_if
// Handshake bundle for the sequential floating-point ALU.
//   Request side : in_valid / in_ready, operands a, b and opcode op.
//   Response side: out_valid / out_ready, result and status flags
//                  overflow, underflow, invalid (valid with out_valid).
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high; valid, once raised, stays raised
// with stable payload until that edge, and ready never depends on valid
// within the same cycle.
// master: the scheduler / testbench side; slave: the ALU.
// ---------------------------------------------------------------------------
interface fp_alu_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic         underflow;
    logic         invalid;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, invalid
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, overflow, underflow, invalid
    );
endinterface

// File: rtl/fp_alu_seq.sv
// ---------------------------------------------------------------------------
// fp_alu_seq
// Multi-cycle floating-point add / sub / mul with truncating rounding,
// flush-to-zero and no subnormal, inf or NaN decoding.
//   clk          : rising-edge clock
//   rst          : asynchronous active-high reset
//   bus          : fp_alu_seq_if.slave (request/response handshake, flags)
//   o_dbg_state  : current FSM state (IDLE=0 ALIGN=1 EXEC=2 NORM=3 DONE=4)
// Opcodes: 00 add, 01 sub (a-b), 10 mul, 11 reserved (flags invalid).
// Flow: IDLE -> ALIGN -> EXEC -> NORM -> DONE -> IDLE. EXEC takes one
// cycle for add/sub/reserved and MAN_W+1 cycles for mul (shift-add).
// ---------------------------------------------------------------------------
module fp_alu_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic               clk,
    input  logic               rst,
    fp_alu_seq_if.slave        bus,
    output logic [2:0]         o_dbg_state
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;            // signed working exponent
    localparam int PW = 2 * MAN_W + 2;        // product width
    localparam int CW = $clog2(MAN_W + 2);    // counter / lz width
    localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_EXEC  = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [W-1:0]          r_a, r_b;
    logic [1:0]            r_op;
    logic                  r_sign, r_eff_sub, r_za, r_zb;
    logic signed [EW-1:0]  r_exp;
    logic [MAN_W+1:0]      r_mx, r_my, r_sum;
    logic [PW-1:0]         r_mcand, r_prod;
    logic [MAN_W:0]        r_mplier;
    logic [CW-1:0]         r_cnt;
    logic [W-1:0]          r_result;
    logic                  r_ovf, r_udf, r_inv;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = S_ALIGN;
            end
            S_ALIGN: w_state_nxt = S_EXEC;
            S_EXEC: begin
                if (r_op != 2'b10 || r_cnt == CW'(MAN_W)) w_state_nxt = S_NORM;
            end
            S_NORM: w_state_nxt = S_DONE;
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_dbg_state   = r_state;
    assign bus.result    = r_result;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_udf;
    assign bus.invalid   = r_inv;

    // ---------------- ALIGN: unpack and order operands ----------------
    logic                 w_sa, w_sb, w_a_ge_b;
    logic [EXP_W-1:0]     w_ea, w_eb, w_e_big, w_e_small, w_diff;
    logic [MAN_W-1:0]     w_ma, w_mb;
    logic [MAN_W:0]       w_m_big, w_m_small, w_m_small_sh;
    logic signed [EW-1:0] w_mul_exp;

    always_comb begin
        w_sa      = r_a[W-1];
        w_sb      = r_b[W-1] ^ (r_op == 2'b01);   // sub negates b
        w_ea      = r_a[W-2 -: EXP_W];
        w_eb      = r_b[W-2 -: EXP_W];
        w_ma      = r_a[MAN_W-1:0];
        w_mb      = r_b[MAN_W-1:0];
        // {exp, man} compares as unsigned magnitude
        w_a_ge_b  = r_a[W-2:0] >= r_b[W-2:0];
        w_e_big   = w_a_ge_b ? w_ea : w_eb;
        w_e_small = w_a_ge_b ? w_eb : w_ea;
        w_m_big   = {1'b1, (w_a_ge_b ? w_ma : w_mb)};
        w_m_small = {1'b1, (w_a_ge_b ? w_mb : w_ma)};
        w_diff    = w_e_big - w_e_small;
        w_m_small_sh = (int'(w_diff) > MAN_W) ? '0 : (w_m_small >> w_diff);
        w_mul_exp = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;
    end

    // ---------------- NORM: leading-zero count ----------------
    logic [CW-1:0] w_lz;
    logic          w_found;

    always_comb begin
        w_lz    = '0;
        w_found = 1'b0;
        for (int i = MAN_W; i >= 0; i--) begin
            if (!w_found) begin
                if (r_sum[i]) w_found = 1'b1;
                else          w_lz    = w_lz + 1'b1;
            end
        end
    end

    // ---------------- NORM: normalise, specials, pack ----------------
    logic [MAN_W-1:0]     w_man;
    logic signed [EW-1:0] w_exp;
    logic                 w_zero, w_exp_ovf, w_exp_udf;
    logic [W-1:0]         w_res;
    logic                 w_ovf, w_udf, w_inv;

    always_comb begin
        w_man  = '0;
        w_exp  = r_exp;
        w_zero = 1'b0;
        w_res  = '0;
        w_ovf  = 1'b0;
        w_udf  = 1'b0;
        w_inv  = 1'b0;
        if (r_op == 2'b10) begin
            // product of two [1,2) mantissas lies in [1,4)
            if (r_prod[PW-1]) begin
                w_man = r_prod[PW-2 -: MAN_W];
                w_exp = r_exp + EW'(1);
            end else begin
                w_man = r_prod[PW-3 -: MAN_W];
            end
            w_zero = r_za | r_zb;
        end else begin
            if (r_sum[MAN_W+1]) begin
                w_man = r_sum[MAN_W:1];
                w_exp = r_exp + EW'(1);
            end else begin
                w_man = MAN_W'(r_sum << w_lz);
                w_exp = r_exp - EW'(w_lz);
            end
            w_zero = (r_sum == '0) || (r_za && r_zb);
        end
        w_exp_ovf = !w_exp[EW-1] && (w_exp >= EXP_MAX);
        w_exp_udf = w_exp[EW-1] || (w_exp == '0);

        if (r_op == 2'b11) begin
            w_inv = 1'b1;
        end else if (r_op != 2'b10 && (r_za ^ r_zb)) begin
            // one zero addend: pass the other through untouched
            w_res = r_za ? {r_b[W-1] ^ r_op[0], r_b[W-2:0]} : r_a;
        end else if (w_zero) begin
            w_res = '0;
        end else if (w_exp_ovf) begin
            w_ovf = 1'b1;
            w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_exp_udf) begin
            w_udf = 1'b1;
        end else begin
            w_res = {r_sign, w_exp[EXP_W-1:0], w_man};
        end
    end

    // Low product bits fall below the truncation point.
    logic w_unused;
    assign w_unused = ^r_prod[MAN_W-1:0];

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_sign    <= 1'b0;
            r_eff_sub <= 1'b0;
            r_za      <= 1'b0;
            r_zb      <= 1'b0;
            r_exp     <= '0;
            r_mx      <= '0;
            r_my      <= '0;
            r_sum     <= '0;
            r_mcand   <= '0;
            r_prod    <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
            r_inv     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a  <= bus.a;
                        r_b  <= bus.b;
                        r_op <= bus.op;
                    end
                end
                S_ALIGN: begin
                    r_cnt  <= '0;
                    r_prod <= '0;
                    r_za   <= (w_ea == '0);
                    r_zb   <= (w_eb == '0);
                    if (r_op == 2'b10) begin
                        r_sign   <= w_sa ^ r_b[W-1];
                        r_exp    <= w_mul_exp;
                        r_mcand  <= {{(PW-MAN_W-1){1'b0}}, 1'b1, w_ma};
                        r_mplier <= {1'b1, w_mb};
                    end else begin
                        r_sign    <= w_a_ge_b ? w_sa : w_sb;
                        r_exp     <= $signed({2'b00, w_e_big});
                        r_mx      <= {1'b0, w_m_big};
                        r_my      <= {1'b0, w_m_small_sh};
                        r_eff_sub <= w_sa ^ w_sb;
                    end
                end
                S_EXEC: begin
                    if (r_op == 2'b10) begin
                        if (r_mplier[0]) r_prod <= r_prod + r_mcand;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                    end else begin
                        r_sum <= r_eff_sub ? (r_mx - r_my) : (r_mx + r_my);
                    end
                end
                S_NORM: begin
                    r_result <= w_res;
                    r_ovf    <= w_ovf;
                    r_udf    <= w_udf;
                    r_inv    <= w_inv;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_alu_seq
// Directed bench for fp_alu_seq at default widths (EXP_W=8, MAN_W=23).
// Expected {overflow, underflow, invalid, result} words are queued when an
// operation is issued and popped when out_valid is seen.
// ---------------------------------------------------------------------------
module tb_fp_alu_seq;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;

    fp_alu_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus_if ();

    fp_alu_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if.slave),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [W+2:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Issues one operation, measures accept-to-out_valid latency (accept
    // edge counted as edge 1), compares the popped expectation, optionally
    // stalls out_ready for `hold` cycles and pokes in_valid meanwhile, and
    // optionally raises out_ready early (right after accept).
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op, input logic [W-1:0] exp_res,
                          input logic [2:0] exp_flags, input int exp_lat,
                          input int hold, input bit early);
        logic [W+2:0] exp_w;
        int lat;
        exp_q.push_back({exp_flags, exp_res});
        @(negedge clk);
        check({tag, " in_ready"}, 64'(bus_if.in_ready), 64'd1);
        bus_if.a        = a;
        bus_if.b        = b;
        bus_if.op       = op;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        bus_if.a        = $urandom;
        bus_if.b        = $urandom;
        bus_if.op       = 2'($urandom_range(0, 3));
        if (early) bus_if.out_ready = 1'b1;
        check({tag, " busy"}, 64'(bus_if.in_ready), 64'd0);
        lat = 1;
        while (!bus_if.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        exp_w = exp_q.pop_front();
        check({tag, " result"}, 64'({bus_if.overflow, bus_if.underflow, bus_if.invalid, bus_if.result}),
              64'(exp_w));
        for (int i = 0; i < hold; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.a        = $urandom;
            bus_if.b        = $urandom;
            bus_if.op       = 2'b00;
            @(posedge clk);
            #1;
            check({tag, " hold valid"}, 64'(bus_if.out_valid), 64'd1);
            check({tag, " hold in_ready"}, 64'(bus_if.in_ready), 64'd0);
            check({tag, " hold result"},
                  64'({bus_if.overflow, bus_if.underflow, bus_if.invalid, bus_if.result}), 64'(exp_w));
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        check({tag, " released valid"}, 64'(bus_if.out_valid), 64'd0);
        check({tag, " released in_ready"}, 64'(bus_if.in_ready), 64'd1);
        if (hold > 0) begin
            @(posedge clk);
            #1;
            check({tag, " stays idle"}, 64'(dbg_state), 64'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.op        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst in_ready",  64'(bus_if.in_ready),  64'd1);
        check("rst out_valid", 64'(bus_if.out_valid), 64'd0);
        check("rst result",    64'(bus_if.result),    64'd0);
        check("rst flags",     64'({bus_if.overflow, bus_if.underflow, bus_if.invalid}), 64'd0);
        check("rst state",     64'(dbg_state),        64'd0);
        rst = 1'b0;

        run_op("add",       32'h40D00000, 32'hC1200000, 2'b00, 32'hC0600000, 3'b000, 4,  0, 1'b0);
        run_op("mul",       32'h40D00000, 32'hC1200000, 2'b10, 32'hC2820000, 3'b000, 27, 0, 1'b0);
        run_op("sub cancel",32'h3F800000, 32'h3F800000, 2'b01, 32'h00000000, 3'b000, 4,  0, 1'b0);
        run_op("add zero",  32'h00000000, 32'hBF800000, 2'b00, 32'hBF800000, 3'b000, 4,  0, 1'b0);
        run_op("sub zero",  32'h00000000, 32'h3F800000, 2'b01, 32'hBF800000, 3'b000, 4,  0, 1'b0);
        run_op("add zero b",32'h40490FDB, 32'h00000000, 2'b00, 32'h40490FDB, 3'b000, 4,  0, 1'b0);
        run_op("mul zero",  32'h00000000, 32'hBF800000, 2'b10, 32'h00000000, 3'b000, 27, 0, 1'b0);
        run_op("trunc",     32'h4121999A, 32'h4129999A, 2'b00, 32'h41A5999A, 3'b000, 4,  0, 1'b1);
        run_op("far shift", 32'h3F800000, 32'h33000000, 2'b00, 32'h3F800000, 3'b000, 4,  0, 1'b0);
        run_op("mul ovf",   32'h7F000000, 32'h40000000, 2'b10, 32'h7F800000, 3'b100, 27, 0, 1'b0);
        run_op("add ovf",   32'h7F7FFFFF, 32'h7F7FFFFF, 2'b00, 32'h7F800000, 3'b100, 4,  0, 1'b0);
        run_op("mul udf",   32'h00800000, 32'h3F000000, 2'b10, 32'h00000000, 3'b010, 27, 0, 1'b0);
        run_op("reserved",  32'h40D00000, 32'hC1200000, 2'b11, 32'h00000000, 3'b001, 4,  0, 1'b0);
        run_op("hold",      32'h40D00000, 32'hC1200000, 2'b00, 32'hC0600000, 3'b000, 4,  5, 1'b0);

        // Reset during mul EXEC, 10 edges after accept.
        @(negedge clk);
        bus_if.a        = 32'h40D00000;
        bus_if.b        = 32'hC1200000;
        bus_if.op       = 2'b10;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre-rst state", 64'(dbg_state), 64'd2);
        #1;
        rst = 1'b1;
        #1;
        check("mid-rst out_valid", 64'(bus_if.out_valid), 64'd0);
        check("mid-rst in_ready",  64'(bus_if.in_ready),  64'd1);
        check("mid-rst outputs",
              64'({bus_if.overflow, bus_if.underflow, bus_if.invalid, bus_if.result}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus_if.out_valid) check("post-rst spurious output", 64'(bus_if.out_valid), 64'd0);
        end
        check("post-rst idle", 64'(dbg_state), 64'd0);

        run_op("mul after rst", 32'h40D00000, 32'hC1200000, 2'b10, 32'hC2820000, 3'b000, 27, 0, 1'b0);

        check("queue drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_alu_seq.md
# fp_alu_seq

Parametrised, multi-cycle successor to the combinational floating-point add/multiply ALU. It adds subtract and a reserved-opcode flag, and supports configurable exponent/mantissa widths. The valid/ready handshake on both sides lets it sit on a shared datapath bus behind a scheduler. It uses an FSM with single-cycle align/normalise, an iterative shift-add multiplier, truncating rounding and flush-to-zero.

## Interface
- `EXP_W`, 8: exponent field width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, 23: stored mantissa width; hidden 1 implied.
- Total word width W = 1+EXP_W+MAN_W.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands/op valid.
- `in_ready`  out  1  block idle and can accept.
- `a`, `b`  in  W  IEEE-style operands {sign, exp, man}.
- `op`  in  2  00 add, 01 sub (a-b), 10 mul, 11 reserved.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `result`  out  W  result word.
- `overflow`, `underflow`, `invalid`  out  1 each  status flags, valid with `out_valid`.

## Operation
- States: IDLE → ALIGN → EXEC → NORM → DONE → IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, capture a, b, op; go ALIGN.
  - Inputs are ignored afterwards.
- ALIGN, 1 cycle:
  - Unpack operands. Exponent field 0 means operand is zero (no subnormals). Sub flips b sign.
  - Add/sub: swap so the larger magnitude is first; right-shift the smaller mantissa by the exponent difference. Shifted-out bits are dropped; a shift of ≥MAN_W+1 gives 0.
  - Mul: e = ea+eb-bias, computed signed in EXP_W+2 bits; sign = sa^sb.
- EXEC:
  - Add/sub: 1 cycle, MAN_W+2-bit add or subtract of magnitudes; sign of larger operand.
  - Mul: MAN_W+1 cycles, one multiplier bit per cycle, 2·MAN_W+2-bit accumulator.
- NORM, 1 cycle:
  - Carry-out: shift right 1, exp+1.
  - Leading zeros: left-shift by the priority-encoded count and subtract from exp.
  - Mul product ≥2: shift right 1, e+1.
  - Truncate to MAN_W bits (round toward zero).
- Special cases (resolved in NORM):
  - Add with one zero operand: result = other operand bit-exact (sub: b with sign flipped).
  - Both zero, exact cancellation, or mul with any zero operand: result = all zeros (+0), flags 0.
  - Final exp ≥ 2^EXP_W-1: `overflow`=1, result = {sign, all-ones exp, 0 man}.
  - Final exp ≤ 0: `underflow`=1, result = all zeros.
  - op=11: `invalid`=1, result = 0, other flags 0; still passes through all states.
- DONE:
  - `out_valid`=1; result and flags are registered and held stable.
  - On `out_valid`&&`out_ready`, go IDLE.
- No inf/NaN input decoding; all-ones exponent inputs are treated as ordinary numbers.

## Timing
- Reset (async, immediate):
  - state=IDLE; `in_ready`=1.
  - `out_valid`, `result`, `overflow`, `underflow`, `invalid` = 0.
  - Reset mid-operation discards the operation; no output is produced.
- Latency from the accept edge to the `out_valid` rising edge:
  - add/sub/reserved: 4 edges.
  - mul: MAN_W+4 edges (27 at default widths).
- `in_ready` deasserts the cycle after accept; one operation in flight at most.
- DONE→IDLE on the handshake edge; `in_ready` is high the following cycle. There is no same-cycle output-take and new-accept.
- `out_ready` held low keeps DONE indefinitely; outputs do not change.
- `in_valid` while busy is ignored; there is no queue and the source must hold its inputs.
- `out_ready` asserted early has no effect before DONE.

## Test plan
- Add 40D00000 (6.5) + C1200000 (-10.0): `out_valid` 4 edges after accept, result C0600000 (-3.5), flags 0.
- Mul 40D00000 × C1200000: `out_valid` 27 edges after accept, result C2820000 (-65.0); sub 3F800000 − 3F800000 gives 00000000.
- Zero handling:
  - add 00000000 + BF800000 gives BF800000.
  - mul 00000000 × BF800000 gives 00000000.
  - 4121999A + 4129999A gives 41A5999A (truncation).
- Flags:
  - mul 7F000000 × 40000000 gives `overflow`=1, result 7F800000.
  - mul 00800000 × 3F000000 gives `underflow`=1, result 00000000.
  - op=11 gives `invalid`=1, result 0.
- Handshake:
  - Hold `out_ready` low 5 cycles after `out_valid`: result stable, `in_ready`=0, second `in_valid` ignored.
  - Release: `in_ready`=1 the next cycle.
- Assert `rst` during mul EXEC (cycle 10):
  - immediately `out_valid`=0, outputs 0, `in_ready`=1.
  - Next op computes correctly.
